// File: rtl/resta_serie_nbit_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Master is the sequencer, slave is the subtractor.
interface resta_serie_nbit_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bi;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         Bo;
  logic         Z;

  modport master (
    output start, A, B, Bi,
    input  busy, done, D, Bo, Z
  );

  modport slave (
    input  start, A, B, Bi,
    output busy, done, D, Bo, Z
  );
endinterface

// File: rtl/resta_serie_nbit.sv
// Bit-serial N-bit subtractor, LSB first, one borrow flop.
// D = (A - B - Bi) mod 2^N, with borrow-out and zero flag.
module resta_serie_nbit #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  resta_serie_nbit_if.slave  s
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_q, w_d;
  logic          bo_q, bo_d;
  logic          z_q, z_d;

  logic          bit_d;
  logic          bit_w;
  logic [N-1:0]  full;

  // One-bit subtract cell on the current LSBs and the borrow flop
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ w_q;
    bit_w = (~a_q[0] & b_q[0])
          | (~(a_q[0] ^ b_q[0]) & w_q);
    full  = {bit_d, r_q[N-1:1]};
  end

  // Next-state, datapath shifting and output loading
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    bo_d    = bo_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          a_d     = s.A;
          b_d     = s.B;
          w_d     = s.Bi;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = full;
        w_d   = bit_w;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          d_d     = full;
          bo_d    = bit_w;
          z_d     = (full == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      bo_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      bo_q    <= bo_d;
      z_q     <= z_d;
    end
  end

  assign s.busy = (state_q == RUN);
  assign s.done = (state_q == DONE);
  assign s.D    = d_q;
  assign s.Bo   = bo_q;
  assign s.Z    = z_q;
endmodule

// File: tb/tb_resta_serie_nbit.sv
// Directed bench for resta_serie_nbit at N=4 and N=8.
// Expected results are hand-computed constants.
module tb_resta_serie_nbit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  resta_serie_nbit_if #(.N(4)) i4 ();
  resta_serie_nbit_if #(.N(8)) i8 ();

  resta_serie_nbit #(.N(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .s   (i4)
  );

  resta_serie_nbit #(.N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .s   (i8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drv(input bit w8, input logic st,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic bi);
    if (w8) begin
      i8.start = st; i8.A = a; i8.B = b; i8.Bi = bi;
    end else begin
      i4.start = st; i4.A = a[3:0]; i4.B = b[3:0]; i4.Bi = bi;
    end
  endtask

  function automatic logic g_busy(input bit w8);
    return w8 ? i8.busy : i4.busy;
  endfunction

  function automatic logic g_done(input bit w8);
    return w8 ? i8.done : i4.done;
  endfunction

  function automatic logic [7:0] g_d(input bit w8);
    return w8 ? i8.D : {4'h0, i4.D};
  endfunction

  function automatic logic g_bo(input bit w8);
    return w8 ? i8.Bo : i4.Bo;
  endfunction

  function automatic logic g_z(input bit w8);
    return w8 ? i8.Z : i4.Z;
  endfunction

  // One operation; operands are scrambled after accept and a start
  // is raised during the DONE cycle, both of which must be ignored.
  task automatic op(input bit w8, input logic [7:0] a,
                    input logic [7:0] b, input logic bi,
                    input logic [7:0] ed, input logic ebo,
                    input logic ez, input string tag);
    int cyc;
    int nb;
    int both;
    int nw;
    nw = w8 ? 8 : 4;
    @(negedge clk);
    drv(w8, 1'b1, a, b, bi);
    @(negedge clk);
    drv(w8, 1'b0, ~a, ~b, ~bi);
    cyc = 0;
    nb = 0;
    both = 0;
    while (!g_done(w8) && cyc < 40) begin
      if (g_busy(w8)) nb++;
      @(negedge clk);
      cyc++;
    end
    if (g_busy(w8) && g_done(w8)) both++;
    chk({tag, "_lat"}, cyc, nw);
    chk({tag, "_busyn"}, nb, nw);
    chk({tag, "_overlap"}, both, 0);
    chk({tag, "_D"}, g_d(w8), ed);
    chk({tag, "_Bo"}, g_bo(w8), ebo);
    chk({tag, "_Z"}, g_z(w8), ez);
    drv(w8, 1'b1, a, b, bi);
    @(negedge clk);
    drv(w8, 1'b0, a, b, bi);
    chk({tag, "_done1"}, g_done(w8), 1'b0);
    chk({tag, "_dnq"}, g_busy(w8), 1'b0);
  endtask

  initial begin
    int k;
    int nd;
    int t1;
    int t2;
    int g;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    drv(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    drv(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", i4.busy, 1'b0);
    chk("rst_done", i4.done, 1'b0);
    chk("rst_D", i4.D, 4'h0);
    chk("rst_Bo", i4.Bo, 1'b0);
    chk("rst_Z", i4.Z, 1'b0);
    chk("rst8_D", i8.D, 8'h00);
    rst = 1'b0;

    op(1'b0, 8'd7, 8'd3, 1'b0, 8'd4, 1'b0, 1'b0, "a7b3");
    op(1'b0, 8'd3, 8'd7, 1'b0, 8'd12, 1'b1, 1'b0, "a3b7");
    op(1'b0, 8'd5, 8'd5, 1'b0, 8'd0, 1'b0, 1'b1, "a5b5");
    op(1'b0, 8'd0, 8'd0, 1'b1, 8'd15, 1'b1, 1'b0, "a0b0bi");
    op(1'b0, 8'd15, 8'd0, 1'b0, 8'd15, 1'b0, 1'b0, "a15b0");

    // start held high: accepts at edges 1, 7, 13; dones after 5, 11
    @(negedge clk);
    drv(1'b0, 1'b1, 8'd9, 8'd2, 1'b0);
    nd = 0;
    t1 = 0;
    t2 = 0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (i4.done) begin
        nd++;
        if (nd == 1) t1 = e;
        if (nd == 2) t2 = e;
        chk("hold_D", i4.D, 4'd7);
      end
    end
    drv(1'b0, 1'b0, 8'd9, 8'd2, 1'b0);
    chk("hold_ndone", nd, 2);
    chk("hold_first", t1, 5);
    chk("hold_period", t2 - t1, 6);
    g = 0;
    while (!i4.done && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("hold_drain", i4.done, 1'b1);
    @(negedge clk);

    // reset during RUN aborts with no done and cleared outputs
    drv(1'b0, 1'b1, 8'd6, 8'd1, 1'b0);
    @(negedge clk);
    drv(1'b0, 1'b0, 8'd6, 8'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", i4.busy, 1'b0);
    chk("abort_D", i4.D, 4'h0);
    chk("abort_Bo", i4.Bo, 1'b0);
    chk("abort_Z", i4.Z, 1'b0);
    k = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (i4.done) k++;
    end
    chk("abort_nodone", k, 0);
    op(1'b0, 8'd6, 8'd1, 1'b0, 8'd5, 1'b0, 1'b0, "a6b1");

    op(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, "w8a80");
    op(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, "w8aff");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
